// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into words and writes them from base_addr.
// Optional IMEM_LOADER_CHECKSUM_EN: after the last word, a 4-byte XOR checksum is received and compared.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_num;
  logic [ADDR_WIDTH:0]   r_widx;
  logic [1:0]            r_bcnt;
  logic [23:0]           r_word;
  logic [DATA_WIDTH-1:0] r_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_csum;
  logic                  r_error;
`endif

  logic                  w_accept;
  logic                  w_last;
  logic [ADDR_WIDTH:0]   w_widx_nxt;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_accept   = in_valid & in_ready;
  assign w_last     = w_accept & (r_bcnt == 2'd3);
  assign w_widx_nxt = r_widx + 1'b1;
  assign w_word     = {in_data, r_word};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_num   <= '0;
      r_widx  <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum  <= '0;
      r_error <= 1'b0;
`endif
    end else if (abort) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
    end else begin
      // Byte counter wraps 3->0 on its own, so word framing needs no extra reset.
      if (w_accept) begin
        r_bcnt <= r_bcnt + 2'd1;
        case (r_bcnt)
          2'd0:    r_word[7:0]   <= in_data;
          2'd1:    r_word[15:8]  <= in_data;
          2'd2:    r_word[23:16] <= in_data;
          default: ;
        endcase
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_base  <= base_addr;
            r_num   <= num_words;
            r_widx  <= '0;
            r_bcnt  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
            r_error <= 1'b0;
`endif
            r_state <= (num_words == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (w_last) begin
            r_addr  <= r_base + r_widx[ADDR_WIDTH-1:0];
            r_data  <= w_word;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_widx <= w_widx_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum <= r_csum ^ r_data;
          r_state <= (w_widx_nxt == r_num) ? S_CHECK : S_RECV;
`else
          r_state <= (w_widx_nxt == r_num) ? S_DONE : S_RECV;
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_last) begin
            r_error <= (w_word != r_csum);
            r_state <= S_DONE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign in_ready = (r_state == S_RECV) || (r_state == S_CHECK);
  assign busy     = (r_state == S_RECV) || (r_state == S_WRITE) || (r_state == S_CHECK);
  assign error    = r_error;
`else
  assign in_ready = (r_state == S_RECV);
  assign busy     = (r_state == S_RECV) || (r_state == S_WRITE);
  assign error    = 1'b0;
`endif
  // A same-cycle abort must kill a write already presented from WRITE.
  assign writeEnable  = (r_state == S_WRITE) && !abort;
  assign writeAddress = r_addr;
  assign writeData    = r_data;
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: word packing, pacing, address wrap, empty load, abort and reset.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [11:0] base_addr;
  logic [12:0] num_words;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        writeEnable;
  logic [11:0] writeAddress;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;
  int we_snap;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .writeEnable(writeEnable), .writeAddress(writeAddress), .writeData(writeData),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (writeEnable) n_we++;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [12:0] n);
    start = 1'b1; base_addr = b; num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = b;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check1("byte_ready_timeout", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [11:0] exp_addr, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i < 3) repeat (gap) tick();
    end
    check1("we_after_byte3", writeEnable, 1'b1);
    check32("write_addr", {20'h0, writeAddress}, {20'h0, exp_addr});
    check32("write_data", writeData, w);
    tick();
    check1("we_single_cycle", writeEnable, 1'b0);
    check32("data_hold", writeData, w);
    repeat (gap) tick();
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic send_cs(input logic [31:0] cs, input logic exp_err);
    for (int i = 0; i < 4; i++) send_byte(cs[8*i +: 8]);
    check1("cs_error", error, exp_err);
    check1("cs_done", done, 1'b1);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_addr = '0; num_words = '0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_we", writeEnable, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_error", error, 1'b0);
    check32("rst_addr", {20'h0, writeAddress}, 32'h0);
    check32("rst_data", writeData, 32'h0);
    reset = 1'b0;
    tick();

    // Basic two-word load
    do_start(12'h010, 13'd2);
    check1("t1_busy", busy, 1'b1);
    check1("t1_ready", in_ready, 1'b1);
    send_word(32'h0000_0013, 12'h010, 0);
    send_word(32'h0010_0093, 12'h011, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check1("t1_not_done_before_cs", done, 1'b0);
    send_cs(32'h0010_0080, 1'b0);
`endif
    check1("t1_done", done, 1'b1);
    check1("t1_busy_end", busy, 1'b0);
    check1("t1_ready_end", in_ready, 1'b0);
    check32("t1_addr_hold", {20'h0, writeAddress}, 32'h011);
    check32("t1_we_count", n_we, 32'd2);

    // Same load with in_valid toggling
    do_start(12'h010, 13'd2);
    check1("t2_done_cleared", done, 1'b0);
    send_word(32'h0000_0013, 12'h010, 1);
    send_word(32'h0010_0093, 12'h011, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_cs(32'h0000_0000, 1'b1);
`endif
    check1("t2_done", done, 1'b1);
    check32("t2_we_count", n_we, 32'd4);

    // Address wrap
    do_start(12'hFFF, 13'd2);
    send_word(32'hDEAD_BEEF, 12'hFFF, 0);
    send_word(32'h1234_5678, 12'h000, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_cs(32'hCC99_E897, 1'b0);
`endif
    check1("t3_done", done, 1'b1);
    check1("t3_error", error, 1'b0);

    // Abort from DONE clears done
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("abort_clears_done", done, 1'b0);

    // Empty load
    we_snap = n_we;
    do_start(12'h100, 13'd0);
    check1("t4_done", done, 1'b1);
    check1("t4_ready", in_ready, 1'b0);
    check1("t4_busy", busy, 1'b0);
    tick();
    check32("t4_no_write", n_we, we_snap);

    // Abort beats a simultaneous start
    start = 1'b1; abort = 1'b1; base_addr = 12'h050; num_words = 13'd1;
    tick();
    start = 1'b0; abort = 1'b0;
    check1("abort_wins_busy", busy, 1'b0);
    check1("abort_wins_done", done, 1'b0);

    // Start ignored mid-load, then abort after two bytes of word 1
    do_start(12'h020, 13'd2);
    do_start(12'h300, 13'd1);
    send_word(32'h1122_3344, 12'h020, 0);
    we_snap = n_we;
    send_byte(8'hAA);
    send_byte(8'hBB);
    check1("t5_busy_mid", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check1("t5_busy", busy, 1'b0);
    check1("t5_done", done, 1'b0);
    check1("t5_ready", in_ready, 1'b0);
    repeat (3) tick();
    check32("t5_no_write", n_we, we_snap);

    // Reset mid-word
    do_start(12'h040, 13'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    we_snap = n_we;
    reset = 1'b1;
    #1;
    check1("t6_busy_async", busy, 1'b0);
    check1("t6_ready_async", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check1("t6_done", done, 1'b0);
    check1("t6_busy", busy, 1'b0);
    check32("t6_no_write", n_we, we_snap);
    check32("t6_addr_cleared", {20'h0, writeAddress}, 32'h0);
    check32("t6_data_cleared", writeData, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the instruction word written to instruction memory; fixed at 4 bytes.
REQ-002 Parameter ADDR_WIDTH, default 12: word-address width of the instruction memory write port.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle load request; samples base_addr and num_words.
REQ-006 abort  input  1  terminates a load in progress.
REQ-007 base_addr  input  ADDR_WIDTH  first word address to write.
REQ-008 num_words  input  ADDR_WIDTH+1  number of words to load; range 0..2^ADDR_WIDTH.
REQ-009 in_valid  input  1  byte-stream valid.
REQ-010 in_data  input  8  byte-stream data, little-endian within each word.
REQ-011 in_ready  output  1  byte-stream ready.
REQ-012 writeEnable  output  1  instruction-memory write strobe.
REQ-013 writeAddress  output  ADDR_WIDTH  instruction-memory write word address.
REQ-014 writeData  output  DATA_WIDTH  instruction-memory write data.
REQ-015 busy  output  1  load in progress; the core is held while busy is high.
REQ-016 done  output  1  last load completed.
REQ-017 error  output  1  checksum mismatch; driven 0 when IMEM_LOADER_CHECKSUM_EN is undefined.

Function
REQ-018 The FSM states SHALL be IDLE, RECV, WRITE, CHECK and DONE; CHECK exists only when IMEM_LOADER_CHECKSUM_EN is defined.
REQ-019 In IDLE or DONE, start SHALL latch base_addr and num_words, clear the byte and word counters, clear done and error, and move to RECV; when num_words=0 it SHALL move to DONE instead.
REQ-020 start SHALL be ignored in RECV, WRITE and CHECK.
REQ-021 in_ready SHALL be 1 only in RECV; a byte SHALL be accepted only when in_valid and in_ready are both 1.
REQ-022 Accepted byte k (k=0..3) of a word SHALL be placed in writeData bits [8k+7:8k].
REQ-023 Acceptance of byte 3 SHALL cause a move to WRITE; writeEnable SHALL be 1 for exactly the single following cycle, with writeAddress = base_addr + word_index (mod 2^ADDR_WIDTH).
REQ-024 After WRITE, word_index SHALL increment; if it equals num_words the FSM SHALL go to DONE (or CHECK), else to RECV.
REQ-025 writeEnable SHALL be 0 in every state other than WRITE; writeAddress and writeData SHALL hold their last values outside WRITE.
REQ-026 busy SHALL be 1 in RECV, WRITE and CHECK; done SHALL be 1 only in DONE and SHALL stay 1 until the next accepted start.
REQ-027 abort SHALL force IDLE on the next edge from any state, suppress any write in that cycle, and clear done; abort SHALL win over a simultaneous start.
REQ-028 Address wrap past 2^ADDR_WIDTH-1 SHALL wrap to 0 without error.

Reset
REQ-029 Asserting reset SHALL immediately force IDLE and clear all counters; in_ready, writeEnable, busy, done and error SHALL be 0; writeAddress and writeData SHALL be 0.
REQ-030 Reset asserted mid-load SHALL discard any partial word; no write SHALL issue.

Configuration
REQ-031 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a running XOR of all written words; after the last WRITE it SHALL enter CHECK, receive 4 further bytes as the checksum word, set error=1 on mismatch, then enter DONE.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, no checksum bytes SHALL be consumed, CHECK SHALL not exist, and error SHALL be tied to 0.

Verification
REQ-033 base_addr=0x010, num_words=2, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013@0x010, then 0x00100093@0x011; done=1.
REQ-034 Same load with in_valid toggling every other cycle -> identical writes; each writeEnable occurs exactly one cycle after byte 3 of its word is accepted.
REQ-035 base_addr=0xFFF, num_words=2 -> writes at 0xFFF, then 0x000.
REQ-036 num_words=0 -> DONE one cycle after start; no writeEnable; in_ready stays 0.
REQ-037 abort after 2 bytes of word 1, and reset asserted mid-word on a separate run -> no write for the partial word; IDLE reached; busy=0, done=0.
REQ-038 With IMEM_LOADER_CHECKSUM_EN defined, words 0x00000013 and 0x00100093 -> checksum 0x00100080 gives error=0; checksum 0x00000000 gives error=1; both runs end with done=1.
